// File: rtl/fifo_syn.sv
// Single-clock synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_SYN_FWFT_EN for first-word-fall-through reads; otherwise rd_data is registered on each accepted read.
module fifo_syn #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_full,
  output logic                      wr_almost_full,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_empty,
  output logic                      rd_almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wa;
  logic                  ra;

  // Flags depend only on the registered count, so requests never reach them combinationally.
  assign wr_full         = (count == CW'(DEPTH));
  assign wr_almost_full  = (count >= CW'(AF_THRESH));
  assign rd_empty        = (count == '0);
  assign rd_almost_empty = (count <= CW'(AE_THRESH));

  assign wa = wr_en & ~wr_full;
  assign ra = rd_en & ~rd_empty;

  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + AW'(1);
      if (ra) rd_ptr <= rd_ptr + AW'(1);
      case ({wa, ra})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A fresh error in the same cycle as clr wins, so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & wr_full) overflow <= 1'b1;
      else if (clr)        overflow <= 1'b0;
      if (rd_en & rd_empty) underflow <= 1'b1;
      else if (clr)         underflow <= 1'b0;
    end
  end

`ifdef FIFO_SYN_FWFT_EN
  assign rd_data = mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_data <= '0;
    else if (ra) rd_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_syn.sv
// Bench for fifo_syn: directed and random traffic compared against a queue-based reference model.
module tb_fifo_syn;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          wr_full, wr_almost_full, rd_empty, rd_almost_empty;
  logic          overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd = '0;
  bit            m_ovf = 0;
  bit            m_unf = 0;

  fifo_syn #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk1({tag, ":count"}, 32'(count), 32'(n));
    chk1({tag, ":empty"}, 32'(rd_empty), 32'(n == 0));
    chk1({tag, ":full"}, 32'(wr_full), 32'(n == DP));
    chk1({tag, ":afull"}, 32'(wr_almost_full), 32'(n >= AF));
    chk1({tag, ":aempty"}, 32'(rd_almost_empty), 32'(n <= AE));
    chk1({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk1({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
`ifdef FIFO_SYN_FWFT_EN
    if (n != 0) chk1({tag, ":rd_data"}, 32'(rd_data), 32'(q[0]));
`else
    chk1({tag, ":rd_data"}, 32'(rd_data), 32'(exp_rd));
`endif
  endtask

  // One clock of traffic; the model decides acceptance from the occupancy before the edge.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit cl, input string tag);
    bit full, empty, acc_w, acc_r;
    wr_en = we; wr_data = wd; rd_en = re; clr = cl;
    full  = (q.size() == DP);
    empty = (q.size() == 0);
    acc_w = we && !full;
    acc_r = re && !empty;
    if (acc_r) exp_rd = q.pop_front();
    if (acc_w) q.push_back(wd);
    if (we && full) m_ovf = 1; else if (cl) m_ovf = 0;
    if (re && empty) m_unf = 1; else if (cl) m_unf = 0;
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; clr = 0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd = '0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    logic [DW-1:0] d;
    bit we, re, cl;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 0;

    // Fill 0x01..0x10
    for (int i = 1; i <= DP; i++) step(1, DW'(i), 0, 0, "fill");

    // Write while full: rejected, overflow set
    step(1, 8'hAA, 0, 0, "ovf_write");
    // Simultaneous at full: only the read is accepted
    step(1, 8'hBB, 1, 0, "full_wr_rd");
    step(0, '0, 0, 1, "clr_ovf");
    step(1, 8'h11, 0, 0, "refill");

    // Drain in order
    for (int i = 0; i < DP; i++) step(0, '0, 1, 0, "drain");

    // Underflow, then simultaneous at empty: only the write is accepted
    step(0, '0, 1, 0, "unf_read");
    step(1, 8'h33, 1, 0, "empty_wr_rd");
    step(0, '0, 1, 0, "read_33");
    // Set beats clr in the same cycle
    step(0, '0, 1, 1, "set_vs_clr");
    step(0, '0, 0, 1, "clr_both");

    // Steady state at count 8
    for (int i = 0; i < 8; i++) begin d = DW'($urandom); step(1, d, 0, 0, "to8"); end
    for (int i = 0; i < 20; i++) begin d = DW'($urandom); step(1, d, 1, 0, "sim8"); end

    // Wrap-around at count ~4
    while (q.size() > 4) step(0, '0, 1, 0, "to4");
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      step(1, d, 0, 0, "wrap_w");
      step(0, '0, 1, 0, "wrap_r");
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d  = DW'($urandom);
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      cl = ($urandom_range(0, 99) < 5);
      step(we, d, re, cl, "rand");
    end

    // Asynchronous reset mid-stream at count 9
    while (q.size() > 9) step(0, '0, 1, 0, "to9_r");
    while (q.size() < 9) begin d = DW'($urandom); step(1, d, 0, 0, "to9_w"); end
    step(1, 8'h5A, 1, 0, "pre_rst");
    @(posedge clk);
    #3 rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 0;

    // First write after reset
    step(1, 8'hC3, 0, 0, "post_rst_w");
    step(0, '0, 1, 0, "post_rst_r");
    step(0, '0, 0, 0, "idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_syn.md
# fifo_syn

Single-clock, parametrised synchronous FIFO; the single-clock successor to the dual-clock FIFO. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. Sits between same-clock producer/consumer blocks wherever rate smoothing is needed without CDC cost.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each entry in bits (>= 1).
- DEPTH, 16, number of entries; power of two, >= 4.
- AF_THRESH, DEPTH-2, wr_almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, rd_almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of error flags only; no effect on data or pointers.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- wr_full  output  1  count == DEPTH.
- wr_almost_full  output  1  count >= AF_THRESH.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  read data.
- rd_empty  output  1  count == 0.
- rd_almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

## Operation

- Storage: DEPTH x DATA_WIDTH register array; wr_ptr, rd_ptr are $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- Write accepted (wa) = wr_en & ~wr_full; stores wr_data at wr_ptr, wr_ptr+1.
- Read accepted (ra) = rd_en & ~rd_empty; rd_ptr+1.
- Acceptance is evaluated on flags at the start of the cycle: when full, wr+rd -> read accepted, write rejected (overflow set); when empty, wr+rd -> write accepted, read rejected (underflow set).
- count next = count + wa - ra; wa & ra leaves count unchanged. All flags are decoded from registered count, never from pointer compare.
- Rejected requests never modify memory, pointers, count or rd_data.
- overflow <= 1 on wr_en & wr_full; underflow <= 1 on rd_en & rd_empty; both hold until clr or rst. Set has priority over clr in the same cycle.
- Reset: pointers, count, overflow, underflow = 0; rd_data = 0; rd_empty = 1, rd_almost_empty = 1, wr_full = 0, wr_almost_full = 0 (AF_THRESH >= 1). Memory contents not reset. Reset mid-operation discards all stored entries immediately (asynchronous).

## Timing

- Flags and count update on the edge following the accepted operation (1-cycle latency); no combinational path from wr_en/rd_en to any flag.
- Standard mode: rd_data is registered, loaded with mem[rd_ptr] on the edge where ra = 1; valid from that edge and held until the next accepted read.
- Write-to-read: entry written at edge N clears rd_empty after edge N; earliest read accepted at edge N+1.
- Full throughput: one write and one read per cycle sustained for 0 < count < DEPTH.

## Configuration

- FIFO_SYN_FWFT_EN defined: first-word-fall-through. rd_data = mem[rd_ptr] combinationally whenever rd_empty = 0 (head visible before rd_en); rd_en acts as acknowledge/pop. rd_data is don't-care while empty. Write at edge N is visible on rd_data after edge N.
- Not defined: standard registered read as above; rd_data updated only on accepted reads; reset value 0.

## Test plan

- Reset/fill (DATA_WIDTH=8, DEPTH=16): after rst, write 0x01..0x10 -> count steps 1..16, wr_almost_full at count 14, wr_full at 16, rd_almost_empty drops at count 3.
- Drain: read 16 -> rd_data 0x01..0x10 in order (standard: one edge after each rd_en), rd_empty after 16th read, count 0.
- Overflow/underflow: write 0xAA while full -> overflow = 1, count stays 16, 17th read never returns 0xAA; read while empty -> underflow = 1; pulse clr -> both 0.
- Simultaneous: at count 8, wr_en & rd_en for 20 cycles -> count stays 8, data order preserved; at full and at empty, simultaneous request -> only read (full) / only write (empty) accepted.
- Wrap-around: 40 writes interleaved with 40 reads at count ~4 -> pointers wrap twice, no data loss or reorder.
- Async reset mid-stream at count 9 -> count 0, rd_empty 1, flags cleared within the same cycle; FWFT build: first write after reset appears on rd_data the next cycle, no rd_en needed.
